// File: rtl/common_pseudo_lru_alloc_ctrl_pkg.sv
// Shared definitions for the pseudo-LRU allocation controller family.
package common_pseudo_lru_alloc_ctrl_pkg;

    // Allocation sequencer states (binary, 2 bits).
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PICK   = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Number of entries managed for a given log2 entry count.
    function automatic int unsigned calc_entry_count(input int unsigned count_log2);
        return 32'd1 << count_log2;
    endfunction

endpackage

// File: rtl/common_pseudo_lru_alloc_candidate.sv
// Candidate mask generator: prefer free entries, else any unlocked entry.
module common_pseudo_lru_alloc_candidate #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] entry_valid_i,
    input  logic [N-1:0] lock_mask_i,
    output logic [N-1:0] cand_o,
    output logic         any_cand_o
);

    logic [N-1:0] free;
    logic         any_free;

    // Free entries win; only when none exist do valid unlocked entries become eviction candidates.
    always_comb begin
        free       = ~entry_valid_i & ~lock_mask_i;
        any_free   = |free;
        cand_o     = any_free ? free : ~lock_mask_i;
        any_cand_o = |cand_o;
    end

endmodule

// File: rtl/common_pseudo_lru_alloc_ctrl.sv
// Allocation controller wrapped around a one-hot pseudo-LRU picker: owns the valid
// bitmap, captures the victim, runs the refill handshake and commits the result.
module common_pseudo_lru_alloc_ctrl
    import common_pseudo_lru_alloc_ctrl_pkg::*;
#(
    parameter  int unsigned SUBJECT_COUNT_LOG2 = 3,
    localparam int unsigned N                  = calc_entry_count(SUBJECT_COUNT_LOG2)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         touch_valid,
    input  logic [N-1:0] touch_onehot,
    input  logic         inval_valid,
    input  logic [N-1:0] inval_mask,
    input  logic [N-1:0] lock_mask,
    input  logic         alloc_valid,
    output logic         alloc_ready,
    output logic         fill_req_valid,
    output logic [N-1:0] fill_req_onehot,
    input  logic         fill_done,
    output logic         alloc_resp_valid,
    output logic [N-1:0] alloc_resp_onehot,
    output logic [N-1:0] entry_valid,
    output logic [N-1:0] plru_waddr,
    output logic         plru_wen,
    output logic [N-1:0] plru_dvalid,
    input  logic [N-1:0] plru_qaddr
);

    logic [1:0]   state_q, state_d;
    logic [N-1:0] victim_q, victim_d;
    logic [N-1:0] entry_valid_q, entry_valid_d;
    logic [N-1:0] cand;
    logic         any_cand;
    logic [N-1:0] inval_eff;

    common_pseudo_lru_alloc_candidate #(
        .N (N)
    ) u_candidate (
        .entry_valid_i (entry_valid_q),
        .lock_mask_i   (lock_mask),
        .cand_o        (cand),
        .any_cand_o    (any_cand)
    );

    assign plru_dvalid = cand;
    assign entry_valid = entry_valid_q;
    assign inval_eff   = inval_valid ? inval_mask : '0;

    // Next-state, victim capture and valid-bitmap update.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        entry_valid_d = entry_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (alloc_valid && any_cand) begin
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                victim_d = plru_qaddr;
                // Candidates can vanish under a lock change; keep sampling until one appears.
                if (plru_qaddr != '0) begin
                    entry_valid_d = entry_valid_q & ~plru_qaddr;
                    state_d       = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                entry_valid_d = entry_valid_q | victim_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Invalidation applies last so it wins over a same-cycle commit.
        entry_valid_d = entry_valid_d & ~inval_eff;
    end

    // Handshake outputs and picker update port; commit owns the update port.
    always_comb begin
        alloc_ready       = 1'b0;
        fill_req_valid    = 1'b0;
        fill_req_onehot   = '0;
        alloc_resp_valid  = 1'b0;
        alloc_resp_onehot = '0;
        plru_wen          = touch_valid;
        plru_waddr        = touch_onehot;
        unique case (state_q)
            ST_IDLE: begin
                alloc_ready = any_cand;
            end
            ST_PICK: begin
            end
            ST_FILL: begin
                fill_req_valid  = 1'b1;
                fill_req_onehot = victim_q;
            end
            ST_COMMIT: begin
                alloc_resp_valid  = 1'b1;
                alloc_resp_onehot = victim_q;
                plru_wen          = 1'b1;
                plru_waddr        = victim_q;
            end
            default: begin
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            victim_q      <= '0;
            entry_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            victim_q      <= victim_d;
            entry_valid_q <= entry_valid_d;
        end
    end

endmodule

// File: tb/tb_common_pseudo_lru_alloc_ctrl.sv
// Directed self-checking bench for the pseudo-LRU allocation controller (N=8).
module tb_common_pseudo_lru_alloc_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       touch_valid;
    logic [7:0] touch_onehot;
    logic       inval_valid;
    logic [7:0] inval_mask;
    logic [7:0] lock_mask;
    logic       alloc_valid;
    logic       alloc_ready;
    logic       fill_req_valid;
    logic [7:0] fill_req_onehot;
    logic       fill_done;
    logic       alloc_resp_valid;
    logic [7:0] alloc_resp_onehot;
    logic [7:0] entry_valid;
    logic [7:0] plru_waddr;
    logic       plru_wen;
    logic [7:0] plru_dvalid;
    logic [7:0] plru_qaddr;

    logic       force_en;
    logic [7:0] force_val;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Picker model: lowest set candidate, or a forced value.
    always_comb begin
        plru_qaddr = force_en ? force_val : (plru_dvalid & (~plru_dvalid + 8'd1));
    end

    common_pseudo_lru_alloc_ctrl #(
        .SUBJECT_COUNT_LOG2 (3)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .touch_valid       (touch_valid),
        .touch_onehot      (touch_onehot),
        .inval_valid       (inval_valid),
        .inval_mask        (inval_mask),
        .lock_mask         (lock_mask),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .fill_req_valid    (fill_req_valid),
        .fill_req_onehot   (fill_req_onehot),
        .fill_done         (fill_done),
        .alloc_resp_valid  (alloc_resp_valid),
        .alloc_resp_onehot (alloc_resp_onehot),
        .entry_valid       (entry_valid),
        .plru_waddr        (plru_waddr),
        .plru_wen          (plru_wen),
        .plru_dvalid       (plru_dvalid),
        .plru_qaddr        (plru_qaddr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one full allocation and captures what was seen in FILL and COMMIT.
    task automatic alloc_once(input int fill_wait,
                              output logic fv, output logic [7:0] foh, output logic [7:0] fev,
                              output logic rv, output logic [7:0] roh,
                              output logic wen, output logic [7:0] waddr);
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        cyc();
        fv  = fill_req_valid;
        foh = fill_req_onehot;
        fev = entry_valid;
        repeat (fill_wait) cyc();
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
        rv    = alloc_resp_valid;
        roh   = alloc_resp_onehot;
        wen   = plru_wen;
        waddr = plru_waddr;
        cyc();
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (entry_valid !== 8'h00) $display("FAIL reset_entry_valid got %h want 00", entry_valid); else n_pass++;
        n_checks++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); else n_pass++;
        n_checks++; if (fill_req_valid !== 1'b0 || fill_req_onehot !== 8'h00)
            $display("FAIL reset_fill_req got %b/%h want 0/00", fill_req_valid, fill_req_onehot); else n_pass++;
        n_checks++; if (alloc_resp_valid !== 1'b0 || alloc_resp_onehot !== 8'h00)
            $display("FAIL reset_resp got %b/%h want 0/00", alloc_resp_valid, alloc_resp_onehot); else n_pass++;
        n_checks++; if (plru_wen !== 1'b0) $display("FAIL reset_plru_wen got %b want 0", plru_wen); else n_pass++;
        n_checks++; if (plru_dvalid !== 8'hFF) $display("FAIL reset_dvalid got %h want FF", plru_dvalid); else n_pass++;
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_first_alloc();
        n_checks++; if (alloc_ready !== 1'b1) $display("FAIL first_ready got %b want 1", alloc_ready); else n_pass++;
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        n_checks++; if (fill_req_valid !== 1'b0 || alloc_ready !== 1'b0)
            $display("FAIL first_pick got fv=%b rdy=%b want 0/0", fill_req_valid, alloc_ready); else n_pass++;
        cyc();
        n_checks++; if (fill_req_valid !== 1'b1 || fill_req_onehot !== 8'h01)
            $display("FAIL first_fill got %b/%h want 1/01", fill_req_valid, fill_req_onehot); else n_pass++;
        n_checks++; if (entry_valid !== 8'h00) $display("FAIL first_fill_ev got %h want 00", entry_valid); else n_pass++;
        cyc();
        cyc();
        n_checks++; if (fill_req_onehot !== 8'h01) $display("FAIL first_fill_stable got %h want 01", fill_req_onehot); else n_pass++;
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
        n_checks++; if (alloc_resp_valid !== 1'b1 || alloc_resp_onehot !== 8'h01)
            $display("FAIL first_resp got %b/%h want 1/01", alloc_resp_valid, alloc_resp_onehot); else n_pass++;
        n_checks++; if (plru_wen !== 1'b1 || plru_waddr !== 8'h01)
            $display("FAIL first_plru got %b/%h want 1/01", plru_wen, plru_waddr); else n_pass++;
        cyc();
        n_checks++; if (entry_valid !== 8'h01 || alloc_resp_valid !== 1'b0)
            $display("FAIL first_commit got ev=%h rv=%b want 01/0", entry_valid, alloc_resp_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic fv, rv, wen;
        logic [7:0] foh, fev, roh, waddr, exp;
        for (int i = 1; i < 8; i++) begin
            exp = 8'h01 << i;
            alloc_once(0, fv, foh, fev, rv, roh, wen, waddr);
            n_checks++; if (fv !== 1'b1 || foh !== exp)
                $display("FAIL b2b_victim_%0d got %b/%h want 1/%h", i, fv, foh, exp); else n_pass++;
            n_checks++; if (rv !== 1'b1 || roh !== exp)
                $display("FAIL b2b_resp_%0d got %b/%h want 1/%h", i, rv, roh, exp); else n_pass++;
        end
        n_checks++; if (entry_valid !== 8'hFF) $display("FAIL b2b_full got %h want FF", entry_valid); else n_pass++;
        n_checks++; if (plru_dvalid !== 8'hFF) $display("FAIL b2b_evict_dvalid got %h want FF", plru_dvalid); else n_pass++;
        alloc_once(1, fv, foh, fev, rv, roh, wen, waddr);
        n_checks++; if (foh !== 8'h01 || fev !== 8'hFE)
            $display("FAIL evict_fill got %h ev=%h want 01 ev=FE", foh, fev); else n_pass++;
        n_checks++; if (entry_valid !== 8'hFF) $display("FAIL evict_commit got %h want FF", entry_valid); else n_pass++;
    endtask

    task automatic test_lock();
        logic fv, rv, wen;
        logic [7:0] foh, fev, roh, waddr;
        lock_mask = 8'hFE;
        #1;
        n_checks++; if (plru_dvalid !== 8'h01 || alloc_ready !== 1'b1)
            $display("FAIL lock_dvalid got %h rdy=%b want 01/1", plru_dvalid, alloc_ready); else n_pass++;
        alloc_once(0, fv, foh, fev, rv, roh, wen, waddr);
        n_checks++; if (foh !== 8'h01 || roh !== 8'h01)
            $display("FAIL lock_victim got %h/%h want 01/01", foh, roh); else n_pass++;
        lock_mask = 8'hFF;
        #1;
        n_checks++; if (alloc_ready !== 1'b0 || plru_dvalid !== 8'h00)
            $display("FAIL lock_all got rdy=%b dv=%h want 0/00", alloc_ready, plru_dvalid); else n_pass++;
        lock_mask = 8'h00;
        cyc();
    endtask

    task automatic test_touch();
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        cyc();
        touch_valid  = 1'b1;
        touch_onehot = 8'h10;
        #1;
        n_checks++; if (plru_wen !== 1'b1 || plru_waddr !== 8'h10)
            $display("FAIL touch_fill got %b/%h want 1/10", plru_wen, plru_waddr); else n_pass++;
        fill_done    = 1'b1;
        touch_onehot = 8'h20;
        cyc();
        fill_done = 1'b0;
        n_checks++; if (plru_wen !== 1'b1 || plru_waddr !== 8'h01 || alloc_resp_valid !== 1'b1)
            $display("FAIL touch_commit got %b/%h rv=%b want 1/01/1", plru_wen, plru_waddr, alloc_resp_valid); else n_pass++;
        touch_valid  = 1'b0;
        touch_onehot = 8'h00;
        cyc();
        n_checks++; if (plru_wen !== 1'b0) $display("FAIL touch_idle got %b want 0", plru_wen); else n_pass++;
    endtask

    task automatic test_inval();
        force_en  = 1'b1;
        force_val = 8'h04;
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        cyc();
        n_checks++; if (fill_req_onehot !== 8'h04 || entry_valid !== 8'hFB)
            $display("FAIL inval_fill got %h ev=%h want 04 ev=FB", fill_req_onehot, entry_valid); else n_pass++;
        inval_valid = 1'b1;
        inval_mask  = 8'h06;
        cyc();
        inval_valid = 1'b0;
        inval_mask  = 8'h00;
        n_checks++; if (entry_valid !== 8'hF9 || fill_req_valid !== 1'b1)
            $display("FAIL inval_during_fill got ev=%h fv=%b want F9/1", entry_valid, fill_req_valid); else n_pass++;
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
        cyc();
        n_checks++; if (entry_valid !== 8'hFD) $display("FAIL inval_fill_commit got %h want FD", entry_valid); else n_pass++;
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        cyc();
        fill_done = 1'b1;
        cyc();
        fill_done   = 1'b0;
        inval_valid = 1'b1;
        inval_mask  = 8'h04;
        n_checks++; if (alloc_resp_valid !== 1'b1 || alloc_resp_onehot !== 8'h04)
            $display("FAIL inval_commit_resp got %b/%h want 1/04", alloc_resp_valid, alloc_resp_onehot); else n_pass++;
        cyc();
        inval_valid = 1'b0;
        inval_mask  = 8'h00;
        n_checks++; if (entry_valid !== 8'hF9) $display("FAIL inval_commit_wins got %h want F9", entry_valid); else n_pass++;
        force_en = 1'b0;
    endtask

    task automatic test_pick_stall();
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
        n_checks++; if (alloc_resp_valid !== 1'b0 || entry_valid !== 8'hF9)
            $display("FAIL stray_fill_done got rv=%b ev=%h want 0/F9", alloc_resp_valid, entry_valid); else n_pass++;
        force_en  = 1'b1;
        force_val = 8'h00;
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        cyc();
        cyc();
        n_checks++; if (fill_req_valid !== 1'b0 || alloc_ready !== 1'b0)
            $display("FAIL pick_stall got fv=%b rdy=%b want 0/0", fill_req_valid, alloc_ready); else n_pass++;
        force_val = 8'h02;
        cyc();
        n_checks++; if (fill_req_valid !== 1'b1 || fill_req_onehot !== 8'h02)
            $display("FAIL pick_resume got %b/%h want 1/02", fill_req_valid, fill_req_onehot); else n_pass++;
        force_en  = 1'b0;
        fill_done = 1'b1;
        cyc();
        fill_done = 1'b0;
        cyc();
        n_checks++; if (entry_valid !== 8'hFB) $display("FAIL pick_commit got %h want FB", entry_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        cyc();
        n_checks++; if (fill_req_valid !== 1'b1 || fill_req_onehot !== 8'h04)
            $display("FAIL rst_pre_fill got %b/%h want 1/04", fill_req_valid, fill_req_onehot); else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++; if (fill_req_valid !== 1'b0 || entry_valid !== 8'h00 || alloc_ready !== 1'b1)
            $display("FAIL rst_mid_fill got fv=%b ev=%h rdy=%b want 0/00/1",
                     fill_req_valid, entry_valid, alloc_ready); else n_pass++;
        cyc();
        resetn = 1'b1;
        cyc();
        n_checks++; if (fill_req_valid !== 1'b0 || entry_valid !== 8'h00)
            $display("FAIL rst_release got fv=%b ev=%h want 0/00", fill_req_valid, entry_valid); else n_pass++;
    endtask

    initial begin
        resetn       = 1'b0;
        touch_valid  = 1'b0;
        touch_onehot = 8'h00;
        inval_valid  = 1'b0;
        inval_mask   = 8'h00;
        lock_mask    = 8'h00;
        alloc_valid  = 1'b0;
        fill_done    = 1'b0;
        force_en     = 1'b0;
        force_val    = 8'h00;
        test_reset();
        test_first_alloc();
        test_back_to_back();
        test_lock();
        test_touch();
        test_inval();
        test_pick_stall();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
